// File: rtl/bcd_counter_if.sv
// Bus bundle for bcd_counter: control inputs, load value and count/status outputs.
interface bcd_counter_if #(
    parameter int DIGITS = 2
) ();
    logic                  en;
    logic                  up;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  wrap;
    logic                  load_err;

    modport master (
        output en, up, clr, load, load_val,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/bcd_counter.sv
// Multi-decade packed-BCD up/down counter with clear, clamped load,
// wrap-or-saturate ends, combinational terminal count and registered
// wrap / invalid-load pulses.
module bcd_counter #(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic          clk,
    input  logic          rstn,
    bcd_counter_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic         load_err_q, load_err_d;
    logic         all9_s, all0_s, tc_s;
    logic [W-1:0] load_clamped_s;
    logic         load_bad_s;

    // Any digit above 9 becomes 9; a stray non-BCD digit can never be loaded.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Ripple increment: a digit steps only while every lower digit rolled over.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Ripple decrement: a digit at 0 borrows and becomes 9; an illegal digit lands on 9.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else if (v[4*i +: 4] > 4'd9) begin
                    r[4*i +: 4] = 4'd9;
                    borrow      = 1'b0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // End-of-range detection and clamped load value with its error flag.
    always_comb begin
        all9_s         = 1'b1;
        all0_s         = 1'b1;
        load_bad_s     = 1'b0;
        load_clamped_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (count_q[4*i +: 4] != 4'd9) all9_s = 1'b0;
            if (count_q[4*i +: 4] != 4'd0) all0_s = 1'b0;
            if (bus.load_val[4*i +: 4] > 4'd9) load_bad_s = 1'b1;
            load_clamped_s[4*i +: 4] = clamp_digit(bus.load_val[4*i +: 4]);
        end
    end

    // Next-state selection with priority clr > load > en.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.clr) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d    = load_clamped_s;
            load_err_d = load_bad_s;
        end else if (bus.en) begin
            if (bus.up) begin
                if (all9_s) begin
                    if (WRAP) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    count_d = bcd_inc(count_q);
                end
            end else begin
                if (all0_s) begin
                    if (WRAP) begin
                        count_d = {DIGITS{4'd9}};
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    count_d = bcd_dec(count_q);
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // Terminal count for cascading: suppressed while clear or load owns the edge.
    always_comb begin
        tc_s = 1'b0;
        if (bus.en && !bus.clr && !bus.load) begin
            tc_s = bus.up ? all9_s : all0_s;
        end else begin
            tc_s = 1'b0;
        end
    end

    // State registers with immediate asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
    assign bus.tc       = tc_s;
endmodule

// File: tb/tb_bcd_counter.sv
// Scoreboard bench for bcd_counter: a wrapping and a saturating 2-digit
// instance share stimulus, plus a cascade of two 1-digit counters.
module tb_bcd_counter;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       casc_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    // Reference state as plain integers 0..99.
    int va = 0, vb = 0, vc = 0;

    typedef struct {
        logic [7:0] a_cnt;
        bit         a_wrap;
        bit         a_tc;
        logic [7:0] b_cnt;
        bit         b_wrap;
        bit         b_tc;
        bit         err;
        logic [7:0] c_cnt;
    } exp_t;

    exp_t sb_q[$];

    bcd_counter_if #(.DIGITS(2)) a_if ();
    bcd_counter_if #(.DIGITS(2)) b_if ();
    bcd_counter_if #(.DIGITS(1)) lo_if ();
    bcd_counter_if #(.DIGITS(1)) hi_if ();

    assign a_if.en = en;   assign a_if.up = up;   assign a_if.clr = clr;
    assign a_if.load = load; assign a_if.load_val = load_val;
    assign b_if.en = en;   assign b_if.up = up;   assign b_if.clr = clr;
    assign b_if.load = load; assign b_if.load_val = load_val;
    assign lo_if.en = casc_en; assign lo_if.up = 1'b1; assign lo_if.clr = 1'b0;
    assign lo_if.load = 1'b0;  assign lo_if.load_val = 4'd0;
    assign hi_if.en = lo_if.tc; assign hi_if.up = 1'b1; assign hi_if.clr = 1'b0;
    assign hi_if.load = 1'b0;   assign hi_if.load_val = 4'd0;

    bcd_counter #(.DIGITS(2), .WRAP(1'b1)) u_a  (.clk(clk), .rstn(rstn), .bus(a_if));
    bcd_counter #(.DIGITS(2), .WRAP(1'b0)) u_b  (.clk(clk), .rstn(rstn), .bus(b_if));
    bcd_counter #(.DIGITS(1), .WRAP(1'b1)) u_lo (.clk(clk), .rstn(rstn), .bus(lo_if));
    bcd_counter #(.DIGITS(1), .WRAP(1'b1)) u_hi (.clk(clk), .rstn(rstn), .bus(hi_if));

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic bit model_tc(input int v, input bit e_i, u_i, c_i, l_i);
        return e_i && !c_i && !l_i && ((u_i && v == 99) || (!u_i && v == 0));
    endfunction

    function automatic void model_step(input int v_in, input bit wm,
                                       input bit e_i, u_i, c_i, l_i,
                                       input logic [7:0] lv,
                                       output int v_out, output bit w_out, output bit e_out);
        int hi, lo;
        v_out = v_in; w_out = 1'b0; e_out = 1'b0;
        hi = int'(lv[7:4]);
        lo = int'(lv[3:0]);
        if (c_i) begin
            v_out = 0;
        end else if (l_i) begin
            if (hi > 9) begin hi = 9; e_out = 1'b1; end
            if (lo > 9) begin lo = 9; e_out = 1'b1; end
            v_out = hi * 10 + lo;
        end else if (e_i) begin
            if (u_i) begin
                if (v_in == 99) begin
                    if (wm) begin v_out = 0; w_out = 1'b1; end
                end else v_out = v_in + 1;
            end else begin
                if (v_in == 0) begin
                    if (wm) begin v_out = 99; w_out = 1'b1; end
                end else v_out = v_in - 1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: apply inputs, check pre-edge tc, push post-edge expectation.
    task automatic drive(input bit e_i, u_i, c_i, l_i, input logic [7:0] lv_i);
        exp_t r;
        int   na, nb;
        bit   wa, wb, ea, eb;
        @(negedge clk);
        #1;
        en = e_i; up = u_i; clr = c_i; load = l_i; load_val = lv_i;
        casc_en = (cyc_n < 25) ? 1'b1 : 1'($urandom_range(0, 1));
        cyc_n++;
        #1;
        check("tc_pre_a", {31'd0, a_if.tc}, {31'd0, model_tc(va, e_i, u_i, c_i, l_i)});
        check("tc_pre_b", {31'd0, b_if.tc}, {31'd0, model_tc(vb, e_i, u_i, c_i, l_i)});
        model_step(va, 1'b1, e_i, u_i, c_i, l_i, lv_i, na, wa, ea);
        model_step(vb, 1'b0, e_i, u_i, c_i, l_i, lv_i, nb, wb, eb);
        va = na; vb = nb;
        if (casc_en) vc = (vc + 1) % 100;
        r.a_cnt = to_bcd(va); r.a_wrap = wa; r.a_tc = model_tc(va, e_i, u_i, c_i, l_i);
        r.b_cnt = to_bcd(vb); r.b_wrap = wb; r.b_tc = model_tc(vb, e_i, u_i, c_i, l_i);
        r.err   = ea;
        r.c_cnt = to_bcd(vc);
        sb_q.push_back(r);
    endtask

    // Monitor: registered outputs are compared mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("count_a",  {24'd0, a_if.count}, {24'd0, e.a_cnt});
                check("wrap_a",   {31'd0, a_if.wrap}, {31'd0, e.a_wrap});
                check("tc_a",     {31'd0, a_if.tc}, {31'd0, e.a_tc});
                check("lerr_a",   {31'd0, a_if.load_err}, {31'd0, e.err});
                check("count_b",  {24'd0, b_if.count}, {24'd0, e.b_cnt});
                check("wrap_b",   {31'd0, b_if.wrap}, {31'd0, e.b_wrap});
                check("tc_b",     {31'd0, b_if.tc}, {31'd0, e.b_tc});
                check("lerr_b",   {31'd0, b_if.load_err}, {31'd0, e.err});
                check("cascade",  {24'd0, hi_if.count, lo_if.count}, {24'd0, e.c_cnt});
            end
        end
    end

    // Stimulus: reset, directed scenarios, async reset, then random traffic.
    initial begin
        #1;
        check("rst_count_a", {24'd0, a_if.count}, 32'd0);
        check("rst_count_b", {24'd0, b_if.count}, 32'd0);
        check("rst_wrap_a",  {31'd0, a_if.wrap}, 32'd0);
        check("rst_lerr_a",  {31'd0, a_if.load_err}, 32'd0);
        check("rst_cascade", {24'd0, hi_if.count, lo_if.count}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_hold_a", {24'd0, a_if.count}, 32'd0);
        rstn = 1'b1;

        // count up through the first decade carry
        repeat (12) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        // wrap at top then bottom
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h98);
        repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // saturation on the non-wrapping instance
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // clamp, clr-over-load, load-over-en
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hA7);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h42);
        // reach 23 then assert reset mid-cycle
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h20);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; casc_en = 1'b0;
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("async_count_a", {24'd0, a_if.count}, 32'd0);
        check("async_count_b", {24'd0, b_if.count}, 32'd0);
        check("async_wrap_a",  {31'd0, a_if.wrap}, 32'd0);
        check("async_lerr_a",  {31'd0, a_if.load_err}, 32'd0);
        check("async_cascade", {24'd0, hi_if.count, lo_if.count}, 32'd0);
        va = 0; vb = 0; vc = 0;
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
                  8'($urandom_range(0, 255)));
        end

        repeat (3) @(negedge clk);
        check("sb_drain", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
